// File: rtl/m68k_bus_arbiter_pkg.sv
// Shared definitions for the 68000 bus arbiter: state encodings, output decode
// and synchronizer defaults.
package m68k_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_OWN     = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_GRANT   = 3'd2,
    ST_EXT     = 3'd3,
    ST_RECLAIM = 3'd4
  } arb_state_t;

  // Edge detection compares the previous and current synchronized sample.
  localparam int EDGE_W = 2;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef struct packed {
    logic bg_n;
    logic hold;
    logic bus_en;
  } arb_out_t;

  function automatic arb_out_t state_outputs(arb_state_t s);
    arb_out_t o;
    o.bg_n   = 1'b1;
    o.hold   = 1'b1;
    o.bus_en = 1'b0;
    case (s)
      ST_OWN: begin
        o.hold   = 1'b0;
        o.bus_en = 1'b1;
      end
      ST_DRAIN: o.bus_en = 1'b1;
      ST_GRANT: o.bg_n   = 1'b0;
      default:  ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/m68k_bus_arbiter_sync_edge.sv
// N-stage synchronizer with rise/fall detection on the synchronized value.
// One extra flop past the chain holds the previous sample for the edge compare.
module sync_edge
  import m68k_bus_arbiter_pkg::*;
#(
  parameter int   STAGES    = DEFAULT_SYNC_STAGES,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES:0]   chain;
  logic [EDGE_W-1:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= {(STAGES + 1){RESET_VAL}};
    else     chain <= {chain[STAGES-1:0], d};
  end

  // {previous, current}
  assign hist = chain[STAGES -: EDGE_W];
  assign q    = chain[STAGES-1];
  assign rise = (hist == 2'b01);
  assign fall = (hist == 2'b10);

endmodule

// File: rtl/m68k_bus_arbiter.sv
// Bus arbitration front end: decides when the PiStorm owns the 68000 bus and
// when it is handed to an external master. Transitions only on M68K_CLK falls.
module m68k_bus_arbiter
  import m68k_bus_arbiter_pkg::*;
#(
  parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
  parameter int GRANT_TIMEOUT  = 16,
  parameter int RECLAIM_CYCLES = 1
) (
  input  logic       PI_CLK,
  input  logic       RST,
  input  logic       M68K_CLK,
  input  logic       M68K_BR_n,
  input  logic       M68K_BGACK_n,
  input  logic       SEQ_IDLE,
  output logic       M68K_BG_n,
  output logic       ARB_HOLD,
  output logic       CPU_BUS_EN,
  output logic       ARB_STALL,
  output logic [2:0] ARB_STATE
);

  localparam int GCW = $clog2(GRANT_TIMEOUT + 1);
  localparam int RCW = (RECLAIM_CYCLES > 0) ? $clog2(RECLAIM_CYCLES + 1) : 1;

  logic c7m_fall, c7m_q_unused, c7m_rise_unused;
  logic br_n_s, br_rise_unused, br_fall_unused;
  logic bgack_n_s, bgack_rise_unused, bgack_fall_unused;
  logic br, bgack;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
    .clk(PI_CLK), .rst(RST), .d(M68K_CLK),
    .q(c7m_q_unused), .rise(c7m_rise_unused), .fall(c7m_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_br (
    .clk(PI_CLK), .rst(RST), .d(M68K_BR_n),
    .q(br_n_s), .rise(br_rise_unused), .fall(br_fall_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_bgack (
    .clk(PI_CLK), .rst(RST), .d(M68K_BGACK_n),
    .q(bgack_n_s), .rise(bgack_rise_unused), .fall(bgack_fall_unused)
  );

  assign br    = ~br_n_s;
  assign bgack = ~bgack_n_s;

  arb_state_t     state, state_nxt;
  logic [GCW-1:0] grant_cnt, gcnt_nxt;
  logic [RCW-1:0] rc_cnt, rc_nxt;
  logic           stall, stall_nxt;
  logic           idle_prev;
  arb_out_t       out_q;

  always_ff @(posedge PI_CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_OWN;
      grant_cnt <= '0;
      rc_cnt    <= '0;
      stall     <= 1'b0;
      idle_prev <= 1'b0;
      out_q     <= state_outputs(ST_OWN);
    end else begin
      state     <= state_nxt;
      grant_cnt <= gcnt_nxt;
      rc_cnt    <= rc_nxt;
      stall     <= stall_nxt;
      out_q     <= state_outputs(state_nxt);
      if (c7m_fall) idle_prev <= SEQ_IDLE;
    end
  end

  always_comb begin
    state_nxt = state;
    gcnt_nxt  = grant_cnt;
    rc_nxt    = rc_cnt;
    stall_nxt = stall;
    if (c7m_fall) begin
      case (state)
        ST_OWN: begin
          if (bgack)   state_nxt = ST_EXT;
          else if (br) state_nxt = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (bgack)    state_nxt = ST_EXT;
          else if (!br) state_nxt = ST_OWN;
          else if (SEQ_IDLE && idle_prev) begin
            state_nxt = ST_GRANT;
            gcnt_nxt  = '0;
          end
        end
        ST_GRANT: begin
          // bgack wins over a simultaneous withdrawal
          if (bgack)    state_nxt = ST_EXT;
          else if (!br) state_nxt = ST_OWN;
          else if (grant_cnt != GCW'(GRANT_TIMEOUT)) begin
            gcnt_nxt = grant_cnt + GCW'(1);
            if (grant_cnt == GCW'(GRANT_TIMEOUT - 1)) stall_nxt = 1'b1;
          end
        end
        ST_EXT: begin
          if (!bgack) begin
            state_nxt = ST_RECLAIM;
            rc_nxt    = RCW'(RECLAIM_CYCLES);
          end
        end
        ST_RECLAIM: begin
          if (rc_cnt <= RCW'(1)) state_nxt = br ? ST_DRAIN : ST_OWN;
          else                   rc_nxt = rc_cnt - RCW'(1);
        end
        default: state_nxt = ST_OWN;
      endcase
      if (state_nxt == ST_OWN && state != ST_OWN) stall_nxt = 1'b0;
    end
  end

  assign M68K_BG_n  = out_q.bg_n;
  assign ARB_HOLD   = out_q.hold;
  assign CPU_BUS_EN = out_q.bus_en;
  assign ARB_STALL  = stall;
  assign ARB_STATE  = state;

endmodule
